// File: rtl/vga_rect_fill_if.sv
// Worker-bus bundle between the rectangle fill engine and the VGA peripheral.
// Write and read request channels, each with a one-cycle ready pulse.
interface vga_rect_fill_if;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byteEn;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_addr;
  logic [3:0]  rd_byteEn;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output wr_addr, wr_data, wr_byteEn, wr_valid,
    input  wr_ready,
    output rd_addr, rd_byteEn, rd_valid,
    input  rd_ready, rd_data
  );

  modport slave (
    input  wr_addr, wr_data, wr_byteEn, wr_valid,
    output wr_ready,
    input  rd_addr, rd_byteEn, rd_valid,
    output rd_ready, rd_data
  );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: clips a command, then streams X/Y/DATA
// register writes to the VGA worker, optionally after a vblank poll.
module vga_rect_fill #(
  parameter logic [31:0] VGA_ADDR = 32'h1000_0000,
  parameter int          MAX_W    = 640,
  parameter int          MAX_H    = 480,
  parameter int          DEPTH    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_x0,
  input  logic [9:0]  cmd_y0,
  input  logic [11:0] cmd_w,
  input  logic [10:0] cmd_h,
  input  logic [23:0] cmd_color,
  input  logic        cmd_wait_vblank,
  output logic        busy,
  output logic        done,
  vga_rect_fill_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, START, POLL, WR_X, WR_Y, WR_DATA, DONE
  } state_t;

  localparam logic [12:0] MW = 13'(MAX_W);
  localparam logic [11:0] MH = 12'(MAX_H);
  localparam logic [23:0] CMASK = (DEPTH == 0) ? 24'hFF_FFFF
                                : 24'((32'd1 << DEPTH) - 32'd1);

  state_t      state_q, state_d;
  logic [10:0] x0_q, x0_d;
  logic [9:0]  y0_q, y0_d;
  logic [11:0] w_q, w_d;
  logic [10:0] h_q, h_d;
  logic [23:0] color_q, color_d;
  logic        vb_q, vb_d;
  logic [11:0] y_q, y_d;
  logic [12:0] cx_q, cx_d;
  logic        wreq_q, wreq_d;
  logic        rreq_q, rreq_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] raddr_q, raddr_d;

  logic [12:0] xe_sum, xe;
  logic [11:0] ye_sum, ye;
  logic        degen, last_col, more_rows;
  logic [31:0] x_word, y_word, pix;
  logic        unused_rd;

  assign xe_sum = {2'b0, x0_q} + {1'b0, w_q};
  assign ye_sum = {2'b0, y0_q} + {1'b0, h_q};
  assign xe     = (xe_sum > MW) ? MW : xe_sum;
  assign ye     = (ye_sum > MH) ? MH : ye_sum;

  // Anything that would produce no pixels finishes without bus traffic
  assign degen = (w_q == 12'd0) || (h_q == 11'd0)
              || ({2'b0, x0_q} >= MW) || ({2'b0, y0_q} >= MH);

  assign last_col  = (cx_q == xe - 13'd1);
  assign more_rows = ((y_q + 12'd1) < ye);
  assign x_word    = {21'b0, x0_q};
  assign y_word    = {20'b0, y_q};
  assign pix       = {8'b0, color_q & CMASK};
  assign unused_rd = &{1'b0, bus.rd_data[31:10]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      vb_q    <= 1'b0;
      y_q     <= '0;
      cx_q    <= '0;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      vb_q    <= vb_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    vb_d    = vb_q;
    y_d     = y_q;
    cx_d    = cx_q;
    wreq_d  = wreq_q;
    rreq_d  = rreq_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          vb_d    = cmd_wait_vblank;
          state_d = START;
        end
      end
      START: begin
        cx_d = {2'b0, x0_q};
        y_d  = {2'b0, y0_q};
        if (degen) begin
          state_d = DONE;
        end else if (vb_q) begin
          state_d = POLL;
          rreq_d  = 1'b1;
          raddr_d = VGA_ADDR + 32'h1c;
        end else begin
          state_d = WR_X;
          wreq_d  = 1'b1;
          waddr_d = VGA_ADDR + 32'h04;
          wdata_d = x_word;
        end
      end
      POLL: begin
        // A nonzero scanline keeps the request up for a re-read
        if (rreq_q && bus.rd_ready && bus.rd_data[9:0] == 10'd0) begin
          rreq_d  = 1'b0;
          state_d = WR_X;
          wreq_d  = 1'b1;
          waddr_d = VGA_ADDR + 32'h04;
          wdata_d = x_word;
        end
      end
      WR_X: begin
        if (wreq_q && bus.wr_ready) begin
          state_d = WR_Y;
          waddr_d = VGA_ADDR + 32'h08;
          wdata_d = y_word;
        end
      end
      WR_Y: begin
        if (wreq_q && bus.wr_ready) begin
          state_d = WR_DATA;
          waddr_d = VGA_ADDR + 32'h0c;
          wdata_d = pix;
        end
      end
      WR_DATA: begin
        if (wreq_q && bus.wr_ready) begin
          if (!last_col) begin
            cx_d = cx_q + 13'd1;
          end else if (more_rows) begin
            y_d     = y_q + 12'd1;
            cx_d    = {2'b0, x0_q};
            state_d = WR_X;
            waddr_d = VGA_ADDR + 32'h04;
            wdata_d = x_word;
          end else begin
            wreq_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mask valid during the ready cycle so the worker never takes a write twice
  assign bus.wr_valid  = wreq_q & ~bus.wr_ready;
  assign bus.rd_valid  = rreq_q & ~bus.rd_ready;
  assign bus.wr_addr   = waddr_q;
  assign bus.wr_data   = wdata_q;
  assign bus.rd_addr   = raddr_q;
  assign bus.wr_byteEn = 4'hF;
  assign bus.rd_byteEn = 4'hF;

  assign busy      = (state_q != IDLE);
  assign cmd_ready = ~busy;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: worker/scanline model logs bus traffic,
// each scenario compares the log against a queue of expected accesses.
module tb_vga_rect_fill;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_x0;
  logic [9:0]  cmd_y0;
  logic [11:0] cmd_w;
  logic [10:0] cmd_h;
  logic [23:0] cmd_color;
  logic        cmd_wait_vblank;
  logic        busy;
  logic        done;

  vga_rect_fill_if bus();

  vga_rect_fill #(
    .VGA_ADDR(BASE),
    .MAX_W(640),
    .MAX_H(480),
    .DEPTH(3)
  ) dut (
    .clock(clk),
    .reset(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0),
    .cmd_y0(cmd_y0),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .cmd_wait_vblank(cmd_wait_vblank),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;
  ev_t exp_q[$];
  ev_t log_q[$];
  logic [31:0] scan_q[$];
  int ackn = 2;
  int wcnt = 0;
  int rcnt = 0;
  int acks = 0;
  int masked = 0;
  int done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Worker and scanline model: ack on the ackn-th valid cycle, log every access
  always @(negedge clk) begin
    if (rst) begin
      bus.wr_ready = 1'b0;
      bus.rd_ready = 1'b0;
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (done) done_cnt++;
      if (bus.rd_ready) begin
        bus.rd_ready = 1'b0;
      end else if (bus.rd_valid) begin
        rcnt++;
        if (rcnt >= ackn) begin
          rcnt = 0;
          bus.rd_data = (scan_q.size() > 0) ? scan_q.pop_front() : 32'd0;
          log_q.push_back({1'b1, bus.rd_addr, bus.rd_data});
          bus.rd_ready = 1'b1;
        end
      end
      if (bus.wr_ready) begin
        bus.wr_ready = 1'b0;
      end else if (bus.wr_valid) begin
        wcnt++;
        if (wcnt >= ackn) begin
          wcnt = 0;
          log_q.push_back({1'b0, bus.wr_addr, bus.wr_data});
          bus.wr_ready = 1'b1;
          #1;
          acks++;
          if (bus.wr_valid === 1'b0) masked++;
        end
      end
    end
  end

  task automatic model_fill(input int x0, input int y0, input int w,
                            input int h, input logic [23:0] color);
    int xe;
    int ye;
    if (w == 0 || h == 0 || x0 >= 640 || y0 >= 480) return;
    xe = (x0 + w > 640) ? 640 : x0 + w;
    ye = (y0 + h > 480) ? 480 : y0 + h;
    for (int y = y0; y < ye; y++) begin
      exp_q.push_back({1'b0, BASE + 32'h04, 32'(x0)});
      exp_q.push_back({1'b0, BASE + 32'h08, 32'(y)});
      for (int x = x0; x < xe; x++)
        exp_q.push_back({1'b0, BASE + 32'h0c, {8'b0, color & 24'h7}});
    end
  endtask

  task automatic apply_cmd(input int x0, input int y0, input int w,
                           input int h, input logic [23:0] color,
                           input logic vb);
    @(negedge clk);
    cmd_x0 = 11'(x0);
    cmd_y0 = 10'(y0);
    cmd_w = 12'(w);
    cmd_h = 11'(h);
    cmd_color = color;
    cmd_wait_vblank = vb;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got rdy=%b busy=%b done=%b want 1 0 0",
               cmd_ready, busy, done);
    end
    vectors++;
    if (bus.wr_valid !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got wr=%b rd=%b want 0 0",
               bus.wr_valid, bus.rd_valid);
    end
    vectors++;
    if (bus.wr_addr !== 32'd0 || bus.wr_data !== 32'd0 ||
        bus.rd_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus got wa=%h wd=%h ra=%h want 0",
               bus.wr_addr, bus.wr_data, bus.rd_addr);
    end
    vectors++;
    if (bus.wr_byteEn !== 4'hF || bus.rd_byteEn !== 4'hF) begin
      errors++;
      $display("FAIL reset_be got %h %h want f f",
               bus.wr_byteEn, bus.rd_byteEn);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    int d0;
    ev_t e;
    ev_t o;
    log_q.delete();
    exp_q.delete();
    ackn = 2;
    d0 = done_cnt;
    model_fill(10, 20, 3, 2, 24'd5);
    apply_cmd(10, 20, 3, 2, 24'd5, 1'b0);
    wait_done(400, ok);
    repeat (4) @(negedge clk);
    #2;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout got no done want done");
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0);
    end
    vectors++;
    if (log_q.size() !== 10) begin
      errors++;
      $display("FAIL basic_count got %0d want 10", log_q.size());
    end
    while (exp_q.size() > 0 && log_q.size() > 0) begin
      e = exp_q.pop_front();
      o = log_q.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_acc got %b %h:%h want %b %h:%h",
                 o.rd, o.addr, o.data, e.rd, e.addr, e.data);
      end
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_clip;
    bit ok;
    ev_t e;
    ev_t o;
    log_q.delete();
    exp_q.delete();
    ackn = 2;
    model_fill(638, 479, 5, 4, 24'hc);
    apply_cmd(638, 479, 5, 4, 24'hc, 1'b0);
    wait_done(400, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL clip_timeout got no done want done");
    end
    vectors++;
    if (log_q.size() !== 4) begin
      errors++;
      $display("FAIL clip_count got %0d want 4", log_q.size());
    end
    while (exp_q.size() > 0 && log_q.size() > 0) begin
      e = exp_q.pop_front();
      o = log_q.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL clip_acc got %b %h:%h want %b %h:%h",
                 o.rd, o.addr, o.data, e.rd, e.addr, e.data);
      end
    end
  endtask

  task automatic test_degenerate;
    int tbl[4][4] = '{'{5, 5, 0, 3}, '{640, 0, 5, 1},
                      '{1, 1, 2, 0}, '{0, 480, 1, 1}};
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      apply_cmd(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 24'd7, 1'b0);
      @(negedge clk);
      #2;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL degen%0d_c1 got done=%b busy=%b want 0 1",
                 i, done, busy);
      end
      @(negedge clk);
      #2;
      vectors++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL degen%0d_done got %b want 1", i, done);
      end
      @(negedge clk);
      #2;
      vectors++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL degen%0d_idle got rdy=%b done=%b want 1 0",
                 i, cmd_ready, done);
      end
      vectors++;
      if (log_q.size() !== 0) begin
        errors++;
        $display("FAIL degen%0d_traffic got %0d want 0", i, log_q.size());
      end
    end
  endtask

  task automatic test_vblank;
    bit ok;
    ev_t e;
    ev_t o;
    log_q.delete();
    exp_q.delete();
    scan_q.delete();
    ackn = 2;
    scan_q.push_back(32'd100);
    scan_q.push_back(32'd50);
    scan_q.push_back(32'd0);
    exp_q.push_back({1'b1, BASE + 32'h1c, 32'd100});
    exp_q.push_back({1'b1, BASE + 32'h1c, 32'd50});
    exp_q.push_back({1'b1, BASE + 32'h1c, 32'd0});
    model_fill(100, 200, 2, 1, 24'd3);
    apply_cmd(100, 200, 2, 1, 24'd3, 1'b1);
    wait_done(400, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL vblank_timeout got no done want done");
    end
    vectors++;
    if (log_q.size() !== 7) begin
      errors++;
      $display("FAIL vblank_count got %0d want 7", log_q.size());
    end
    while (exp_q.size() > 0 && log_q.size() > 0) begin
      e = exp_q.pop_front();
      o = log_q.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL vblank_acc got %b %h:%h want %b %h:%h",
                 o.rd, o.addr, o.data, e.rd, e.addr, e.data);
      end
    end
  endtask

  task automatic test_handshake;
    bit ok;
    ev_t e;
    ev_t o;
    log_q.delete();
    exp_q.delete();
    ackn = 1;
    acks = 0;
    masked = 0;
    model_fill(5, 6, 4, 2, 24'd2);
    apply_cmd(5, 6, 4, 2, 24'd2, 1'b0);
    wait_done(400, ok);
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL hs_timeout got no done want done");
    end
    vectors++;
    if (acks !== 12) begin
      errors++;
      $display("FAIL hs_acks got %0d want 12", acks);
    end
    vectors++;
    if (masked !== acks) begin
      errors++;
      $display("FAIL hs_mask got %0d masked want %0d", masked, acks);
    end
    vectors++;
    if (log_q.size() !== 12) begin
      errors++;
      $display("FAIL hs_count got %0d want 12", log_q.size());
    end
    while (exp_q.size() > 0 && log_q.size() > 0) begin
      e = exp_q.pop_front();
      o = log_q.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL hs_acc got %b %h:%h want %b %h:%h",
                 o.rd, o.addr, o.data, e.rd, e.addr, e.data);
      end
    end
    ackn = 2;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0;
    ev_t e;
    ev_t o;
    log_q.delete();
    exp_q.delete();
    ackn = 2;
    apply_cmd(0, 0, 4, 3, 24'd1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (log_q.size() >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL rmid_reach got %0d writes want 9", log_q.size());
    end
    @(negedge clk);
    #2;
    vectors++;
    if (bus.wr_valid !== 1'b1 || bus.wr_addr !== BASE + 32'h0c) begin
      errors++;
      $display("FAIL rmid_pre got v=%b a=%h want 1 %h",
               bus.wr_valid, bus.wr_addr, BASE + 32'h0c);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.wr_valid !== 1'b0 || bus.rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_post got wr=%b rd=%b busy=%b want 0 0 0",
               bus.wr_valid, bus.rd_valid, busy);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    vectors++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL rmid_nodone got %0d pulses want 0", done_cnt - d0);
    end
    log_q.delete();
    model_fill(1, 1, 2, 1, 24'd6);
    apply_cmd(1, 1, 2, 1, 24'd6, 1'b0);
    wait_done(400, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL rmid_timeout got no done want done");
    end
    vectors++;
    if (log_q.size() !== 4) begin
      errors++;
      $display("FAIL rmid_count got %0d want 4", log_q.size());
    end
    while (exp_q.size() > 0 && log_q.size() > 0) begin
      e = exp_q.pop_front();
      o = log_q.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL rmid_acc got %b %h:%h want %b %h:%h",
                 o.rd, o.addr, o.data, e.rd, e.addr, e.data);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0 = '0;
    cmd_y0 = '0;
    cmd_w = '0;
    cmd_h = '0;
    cmd_color = '0;
    cmd_wait_vblank = 1'b0;
    bus.wr_ready = 1'b0;
    bus.rd_ready = 1'b0;
    bus.rd_data = '0;
    test_reset();
    test_basic();
    test_clip();
    test_degenerate();
    test_vblank();
    test_handshake();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
